// File: rtl/reflet_mem_arbiter.sv
// reflet_mem_arbiter: shares one RAM port between two word-wide requesters.
//   Port 0 is the CPU address unit, port 1 a secondary master (DMA/debug).
//   Each access is sequenced as address phase, read-latency wait and a
//   one-cycle completion. All RAM-side outputs come straight from registers.
// Build option: define REFLET_ARB_FIXED_PRIORITY_EN to make port 0 win every
//   tie (no round-robin pointer; port 1 can starve). Default is round-robin.
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and keeps it
//   high until it sees ackN. ackN is a single-cycle pulse, stretched while
//   enable is low. rdataN holds read data from the ackN cycle until that
//   port's next read completes. A req still high on the edge that ends the
//   IDLE cycle after DONE starts a new access.
module reflet_mem_arbiter #(
  parameter int wordsize     = 16,
  parameter int read_latency = 1    // 1..3 RAM cycles after the address is registered
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                req0,
  input  logic                we0,
  input  logic [wordsize-1:0] addr0,
  input  logic [wordsize-1:0] wdata0,
  output logic [wordsize-1:0] rdata0,
  output logic                ack0,
  input  logic                req1,
  input  logic                we1,
  input  logic [wordsize-1:0] addr1,
  input  logic [wordsize-1:0] wdata1,
  output logic [wordsize-1:0] rdata1,
  output logic                ack1,
  output logic [wordsize-1:0] ram_addr,
  output logic [wordsize-1:0] ram_data_out,
  output logic                ram_write_en,
  input  logic [wordsize-1:0] ram_data_in,
  output logic                busy,
  output logic                grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  // Loaded on entry to WAIT; the access completes on the edge where it is 0.
  localparam logic [1:0] lat_m1 = 2'(read_latency - 1);

  state_t              state, state_next;
  logic [1:0]          count, count_next;
  logic                grant_next;
  logic [wordsize-1:0] addr_next, dout_next;
  logic                we_next;
  logic                ack0_next, ack1_next;
  logic [wordsize-1:0] rdata0_next, rdata1_next;
  logic                winner;

`ifdef REFLET_ARB_FIXED_PRIORITY_EN
  // Port 0 wins whenever it asks; port 1 only gets the RAM when port 0 is quiet.
  assign winner = ~req0;
`else
  // Port served most recently; on a tie the other port wins.
  logic last;

  assign winner = (req0 & req1) ? ~last : req1;

  // Round-robin pointer, updated only when an access is started from IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (enable && (state == IDLE) && (req0 | req1)) begin
      last <= winner;
    end
  end
`endif

  assign busy = (state != IDLE);

  // State and output registers; enable low freezes everything, reset wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= 2'd0;
      grant        <= 1'b0;
      ram_addr     <= '0;
      ram_data_out <= '0;
      ram_write_en <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
    end else if (enable) begin
      state        <= state_next;
      count        <= count_next;
      grant        <= grant_next;
      ram_addr     <= addr_next;
      ram_data_out <= dout_next;
      ram_write_en <= we_next;
      ack0         <= ack0_next;
      ack1         <= ack1_next;
      rdata0       <= rdata0_next;
      rdata1       <= rdata1_next;
    end
  end

  // Next-state and next-output logic; every register holds unless a state says otherwise.
  always_comb begin
    state_next  = state;
    count_next  = count;
    grant_next  = grant;
    addr_next   = ram_addr;
    dout_next   = ram_data_out;
    we_next     = ram_write_en;
    ack0_next   = ack0;
    ack1_next   = ack1;
    rdata0_next = rdata0;
    rdata1_next = rdata1;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          grant_next = winner;
          addr_next  = winner ? addr1  : addr0;
          dout_next  = winner ? wdata1 : wdata0;
          we_next    = winner ? we1    : we0;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // The registered write strobe tells us which kind of access this is.
        if (ram_write_en) begin
          we_next    = 1'b0;
          ack0_next  = ~grant;
          ack1_next  = grant;
          state_next = DONE;
        end else begin
          count_next = lat_m1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (count == 2'd0) begin
          if (grant) rdata1_next = ram_data_in;
          else       rdata0_next = ram_data_in;
          ack0_next  = ~grant;
          ack1_next  = grant;
          state_next = DONE;
        end else begin
          count_next = count - 2'd1;
        end
      end
      DONE: begin
        ack0_next  = 1'b0;
        ack1_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/reflet_mem_arbiter.md
Name: reflet_mem_arbiter

Overview:
Shares the single RAM port between two word-wide requesters: port 0 is the CPU address unit and port 1 is a secondary master (DMA or debug).
- Each requester uses a level request with a single-cycle acknowledge.
- The arbiter sequences the access (address phase, read-latency wait, completion) and returns read data in a per-port register.
- It sits between the CPU memory interface and the RAM; all RAM-side outputs are registered.

Parameters:
wordsize, 16, width of addresses and data words on all ports.
read_latency, 1, RAM read latency in cycles after the address is registered (1..3); the wait counter is 2 bits wide.

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low
enable  input  1  clock enable; when low, all state and outputs hold
req0  input  1  port 0 access request, level; held until ack0
we0  input  1  port 0 write (1) / read (0); stable while req0
addr0  input  wordsize  port 0 address; stable while req0
wdata0  input  wordsize  port 0 write data; stable while req0
rdata0  output  wordsize  port 0 read data; valid from the ack0 cycle until its next read completes
ack0  output  1  port 0 completion pulse, one cycle
req1, we1, addr1, wdata1, rdata1, ack1  same as port 0, for port 1
ram_addr  output  wordsize  RAM address
ram_data_out  output  wordsize  RAM write data
ram_write_en  output  1  RAM write strobe
ram_data_in  input  wordsize  RAM read data
busy  output  1  high whenever state is not IDLE
grant  output  1  index of the port being served; holds the last value in IDLE

Behaviour:
- States: IDLE, ACCESS, WAIT, DONE. Every edge described below assumes enable=1.
- Reset (reset=0 at an edge):
  - state=IDLE, all outputs 0, wait counter 0, round-robin pointer last=1.
  - This aborts any access in progress; ram_write_en is 0 after that edge.
- IDLE:
  - Samples req0/req1. If neither is set, stay in IDLE.
  - Otherwise select a winner w. With one request, that port wins. With both, the port != last wins.
  - Then: last<=w, grant<=w, ram_addr<=addr_w, ram_data_out<=wdata_w, ram_write_en<=we_w, go to ACCESS.
- ACCESS (1 cycle):
  - Write: ram_write_en<=0, go to DONE, ack_w<=1.
  - Read: counter<=read_latency-1, go to WAIT.
- WAIT:
  - ram_addr is held.
  - If counter==0: rdata_w<=ram_data_in, ack_w<=1, go to DONE. Otherwise decrement the counter.
- DONE (1 cycle, ack_w high):
  - ack_w<=0, go to IDLE. Requests are not sampled in DONE.
  - The requester must have req low by the edge ending the IDLE cycle that follows, or a new access starts.
- Latency from the IDLE sampling edge to ack:
  - Write: ack is high in cycle 2.
  - Read: ack is high in cycle 2+read_latency (cycle 3 for the default).
- Throughput: at most one access every 3 cycles for writes and every 3+read_latency cycles for reads.
- The non-granted port's request stays pending with no ack. Its rdata register is untouched.
- Simultaneous requests alternate strictly. A continuously requesting port is never served twice in a row while the other port is waiting.
- ram_data_out and ram_addr keep their last values in IDLE. Only ram_write_en carries meaning.
- enable=0 freezes state, the counter, and all outputs, including a high ram_write_en or ack. Requesters must tolerate the stretched ack.

Optional Feature:
Macro REFLET_ARB_FIXED_PRIORITY_EN.
- Defined: port 0 always wins when both ports request. The last pointer is not implemented. Port 1 can starve.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Read port 0: preload RAM[0x0010]=0xBEEF; req0=1, we0=0, addr0=0x0010 -> ram_addr=0x0010 in the ACCESS cycle, ack0 high 3 cycles after sampling, rdata0=0xBEEF, busy high for those 3 cycles.
- Write port 1: req1=1, we1=1, addr1=0x0020, wdata1=0x1234 -> ram_write_en high for exactly 1 cycle with ram_addr=0x0020 and ram_data_out=0x1234; ack1 in the following cycle; a later read returns 0x1234.
- Contention: req0 and req1 held high continuously from reset with reads -> grant sequence 0,1,0,1; each ack alternates and no port is served twice consecutively.
- Sweep read_latency over 1, 2, 3 -> ack at cycles 3, 4, 5 after sampling; rdata captured from ram_data_in on the last WAIT edge.
- Abort and freeze:
  - reset=0 asserted in the ACCESS cycle of a write -> ram_write_en=0 and state IDLE after the edge; no ack is issued.
  - enable=0 held for 4 cycles in WAIT -> no state change; ack arrives 4 cycles late.
- With REFLET_ARB_FIXED_PRIORITY_EN defined and both ports requesting continuously -> grant stays 0 and ack1 never asserts.
